// File: rtl/pll_lock_supervisor_if.sv
// Status/control bundle between the PLL lock supervisor and the surrounding top level.
// The master side drives restart and carries LOCK in from the PLL; the supervisor is the slave.
interface pll_lock_supervisor_if;
  logic       restart;
  logic       pll_locked;
  logic       pll_resetb;
  logic       sys_rst_n;
  logic       pll_ready;
  logic       fault;
  logic [1:0] retry_count;
  logic [7:0] unlock_count;

  modport master (
    output restart, pll_locked,
    input  pll_resetb, sys_rst_n, pll_ready, fault, retry_count, unlock_count
  );

  modport slave (
    input  restart, pll_locked,
    output pll_resetb, sys_rst_n, pll_ready, fault, retry_count, unlock_count
  );
endinterface

// File: rtl/pll_lock_supervisor.sv
// Brings up the SB_PLL40 from the 12 MHz reference: pulses RESETB, waits for a stable LOCK,
// then releases the fast-domain reset; retries on timeout or lock loss, faulting after MAX_RETRIES.
module pll_lock_supervisor #(
  parameter int RESET_CYCLES  = 16,
  parameter int LOCK_TIMEOUT  = 1200,
  parameter int STABLE_CYCLES = 120,
  parameter int MAX_RETRIES   = 3,
  parameter int CNT_W         = 16
) (
  input  logic                   clock_in,
  input  logic                   reset_n,
  pll_lock_supervisor_if.slave   bus
);

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  // Attempt counter is wide enough for MAX_RETRIES; the port view saturates at 3.
  localparam int RW = ($clog2(MAX_RETRIES + 1) < 2) ? 2 : $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0] RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0]    RETRY_LIMIT  = RW'(MAX_RETRIES);

  logic             lk_meta;
  logic             lk;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] timer_nxt;
  logic [RW-1:0]    attempts;
  logic [RW-1:0]    attempts_nxt;
  logic [7:0]       unlock_nxt;

  // LOCK comes straight from the PLL analog block, so it is resynchronised before use.
  // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      lk_meta <= 1'b0;
      lk      <= 1'b0;
    end else begin
      lk_meta <= bus.pll_locked;
      lk      <= lk_meta;
    end
  end

  // NOTE: every variable gets a default at the top of the block so no path can infer a latch.
  always_comb begin
    state_nxt    = state;
    timer_nxt    = timer + CNT_W'(1);
    attempts_nxt = attempts;
    unlock_nxt   = bus.unlock_count;

    case (state)
      PLL_RST: begin
        if (timer == RESET_LAST) state_nxt = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        // A lock seen on the expiry cycle still counts as a lock.
        if (lk) begin
          state_nxt = STABLE;
        end else if (timer == TIMEOUT_LAST) begin
          attempts_nxt = attempts + RW'(1);
          state_nxt    = (attempts_nxt == RETRY_LIMIT) ? FAULT : PLL_RST;
        end
      end
      STABLE: begin
        // Any dropout restarts the stability window, even on its final cycle.
        if (!lk) begin
          state_nxt = WAIT_LOCK;
        end else if (timer == STABLE_LAST) begin
          state_nxt    = RUN;
          attempts_nxt = '0;
        end
      end
      RUN: begin
        timer_nxt = '0;
        if (!lk) begin
          if (bus.unlock_count != 8'hFF) unlock_nxt = bus.unlock_count + 8'd1;
          state_nxt = PLL_RST;
        end
      end
      FAULT: begin
        timer_nxt = '0;
      end
      default: begin
        state_nxt = PLL_RST;
      end
    endcase

    if (bus.restart) begin
      state_nxt    = PLL_RST;
      attempts_nxt = '0;
    end

    if (bus.restart || (state_nxt != state)) timer_nxt = '0;
  end

  // Outputs decode the next state so they change on the same edge as the state itself.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state            <= PLL_RST;
      timer            <= '0;
      attempts         <= '0;
      bus.retry_count  <= 2'd0;
      bus.unlock_count <= 8'd0;
      bus.pll_resetb   <= 1'b0;
      bus.sys_rst_n    <= 1'b0;
      bus.pll_ready    <= 1'b0;
      bus.fault        <= 1'b0;
    end else begin
      state            <= state_nxt;
      timer            <= timer_nxt;
      attempts         <= attempts_nxt;
      bus.retry_count  <= (int'(attempts_nxt) > 3) ? 2'd3 : attempts_nxt[1:0];
      bus.unlock_count <= unlock_nxt;
      bus.pll_resetb   <= (state_nxt == WAIT_LOCK) || (state_nxt == STABLE) || (state_nxt == RUN);
      bus.sys_rst_n    <= (state_nxt == RUN);
      bus.pll_ready    <= (state_nxt == RUN);
      bus.fault        <= (state_nxt == FAULT);
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: directed scenarios plus random LOCK chatter,
// all compared against a phase/elapsed-time reference model of the bring-up rules.
module tb_pll_lock_supervisor;

  localparam int RC = 4;
  localparam int TO = 20;
  localparam int SC = 8;
  localparam int MR = 3;

  localparam int PH_RST    = 10;
  localparam int PH_WAIT   = 11;
  localparam int PH_STABLE = 12;
  localparam int PH_RUN    = 13;
  localparam int PH_FAULT  = 14;

  logic clock_in = 1'b0;
  logic reset_n  = 1'b0;

  pll_lock_supervisor_if bus ();

  pll_lock_supervisor #(
    .RESET_CYCLES (RC),
    .LOCK_TIMEOUT (TO),
    .STABLE_CYCLES(SC),
    .MAX_RETRIES  (MR),
    .CNT_W        (16)
  ) dut (
    .clock_in(clock_in),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock_in = ~clock_in;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: which phase of bring-up we are in and how long we have been there.
  int m_phase;
  int m_el;
  int m_tries;
  int m_unl;
  bit m_sync[2];

  task automatic model_reset();
    m_phase   = PH_RST;
    m_el      = 0;
    m_tries   = 0;
    m_unl     = 0;
    m_sync[0] = 1'b0;
    m_sync[1] = 1'b0;
  endtask

  task automatic model_step(input bit r, input bit locked);
    bit seen;
    seen      = m_sync[1];
    m_sync[1] = m_sync[0];
    m_sync[0] = locked;
    if (r) begin
      m_phase = PH_RST;
      m_el    = 0;
      m_tries = 0;
      return;
    end
    if (m_phase == PH_RST) begin
      if (m_el >= RC - 1) begin m_phase = PH_WAIT; m_el = 0; end
      else m_el++;
    end else if (m_phase == PH_WAIT) begin
      if (seen) begin
        m_phase = PH_STABLE; m_el = 0;
      end else if (m_el >= TO - 1) begin
        m_tries++;
        m_phase = (m_tries == MR) ? PH_FAULT : PH_RST;
        m_el    = 0;
      end else m_el++;
    end else if (m_phase == PH_STABLE) begin
      if (!seen) begin
        m_phase = PH_WAIT; m_el = 0;
      end else if (m_el >= SC - 1) begin
        m_phase = PH_RUN; m_el = 0; m_tries = 0;
      end else m_el++;
    end else if (m_phase == PH_RUN) begin
      if (!seen) begin
        m_unl   = (m_unl < 255) ? m_unl + 1 : 255;
        m_phase = PH_RST;
        m_el    = 0;
      end
    end
  endtask

  function automatic logic [13:0] model_vec();
    logic rb, up, flt;
    rb  = (m_phase == PH_WAIT) || (m_phase == PH_STABLE) || (m_phase == PH_RUN);
    up  = (m_phase == PH_RUN);
    flt = (m_phase == PH_FAULT);
    return {rb, up, up, flt, 2'((m_tries > 3) ? 3 : m_tries), 8'(m_unl)};
  endfunction

  function automatic logic [13:0] dut_vec();
    return {bus.pll_resetb, bus.sys_rst_n, bus.pll_ready, bus.fault,
            bus.retry_count, bus.unlock_count};
  endfunction

  task automatic tick();
    @(posedge clock_in);
    model_step(bus.restart, bus.pll_locked);
    @(negedge clock_in);
  endtask

  task automatic pulse_restart();
    bus.restart = 1'b1;
    tick();
    bus.restart = 1'b0;
  endtask

  task automatic test_reset();
    bus.restart    = 1'b0;
    bus.pll_locked = 1'b0;
    reset_n        = 1'b0;
    model_reset();
    repeat (3) @(negedge clock_in);
    n_checks++;
    if (dut_vec() !== 14'h0) begin
      n_fail++;
      $display("FAIL reset_values: got %h expected %h", dut_vec(), 14'h0);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_bringup();
    int first_ready;
    first_ready = -1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL bringup_model c=%0d: got %h expected %h", c, dut_vec(), model_vec());
      end
      if (c == 3) begin
        n_checks++;
        if (bus.pll_resetb !== 1'b0) begin
          n_fail++;
          $display("FAIL bringup_resetb_low: got %b expected 0", bus.pll_resetb);
        end
      end
      if (c == 4) begin
        n_checks++;
        if (bus.pll_resetb !== 1'b1) begin
          n_fail++;
          $display("FAIL bringup_resetb_high: got %b expected 1", bus.pll_resetb);
        end
      end
      if (first_ready < 0 && bus.pll_ready === 1'b1) first_ready = c;
      if (c == 10) bus.pll_locked = 1'b1;
    end
    // LOCK at 10 -> lk at 12 -> STABLE at 13 -> RUN after 8 STABLE cycles at 21.
    n_checks++;
    if (first_ready != 21) begin
      n_fail++;
      $display("FAIL bringup_release_cycle: got %0d expected 21", first_ready);
    end
    n_checks++;
    if (bus.sys_rst_n !== 1'b1 || bus.retry_count !== 2'd0) begin
      n_fail++;
      $display("FAIL bringup_run_state: got sys_rst_n=%b retry=%0d expected 1/0",
               bus.sys_rst_n, bus.retry_count);
    end
  endtask

  task automatic test_timeout();
    int  high_len;
    bit  seen_low;
    bit  done;
    bus.pll_locked = 1'b0;
    pulse_restart();
    high_len = 0;
    seen_low = 1'b0;
    done     = 1'b0;
    for (int c = 0; c < 80 && !done; c++) begin
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL timeout_model c=%0d: got %h expected %h", c, dut_vec(), model_vec());
      end
      if (bus.pll_resetb === 1'b0 && seen_low && high_len > 0) done = 1'b1;
      else if (bus.pll_resetb === 1'b0) seen_low = 1'b1;
      else if (seen_low) high_len++;
      if (!done) tick();
    end
    n_checks++;
    if (high_len != TO) begin
      n_fail++;
      $display("FAIL timeout_wait_len: got %0d expected %0d", high_len, TO);
    end
    n_checks++;
    if (bus.retry_count !== 2'd1) begin
      n_fail++;
      $display("FAIL timeout_retry_count: got %0d expected 1", bus.retry_count);
    end
    bus.pll_locked = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      tick();
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL recover_model c=%0d: got %h expected %h", c, dut_vec(), model_vec());
      end
      if (bus.pll_ready === 1'b1) done = 1'b1;
    end
    n_checks++;
    if (!done || bus.retry_count !== 2'd0) begin
      n_fail++;
      $display("FAIL recover_run: got ready=%b retry=%0d expected 1/0", done, bus.retry_count);
    end
  endtask

  task automatic test_fault();
    int rises;
    bit prev;
    bit done;
    bus.pll_locked = 1'b0;
    pulse_restart();
    rises = 0;
    prev  = bus.pll_resetb;
    done  = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      tick();
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL fault_model c=%0d: got %h expected %h", c, dut_vec(), model_vec());
      end
      if (bus.pll_resetb === 1'b1 && !prev) rises++;
      prev = bus.pll_resetb;
      if (bus.fault === 1'b1) done = 1'b1;
    end
    n_checks++;
    if (!done || bus.pll_resetb !== 1'b0 || bus.retry_count !== 2'd3 || rises != MR) begin
      n_fail++;
      $display("FAIL fault_entry: got fault=%b resetb=%b retry=%0d attempts=%0d expected 1/0/3/%0d",
               done, bus.pll_resetb, bus.retry_count, rises, MR);
    end
    repeat (10) tick();
    n_checks++;
    if (bus.fault !== 1'b1 || bus.pll_resetb !== 1'b0) begin
      n_fail++;
      $display("FAIL fault_sticky: got fault=%b resetb=%b expected 1/0", bus.fault, bus.pll_resetb);
    end
    pulse_restart();
    n_checks++;
    if (bus.fault !== 1'b0 || bus.retry_count !== 2'd0 || dut_vec() !== model_vec()) begin
      n_fail++;
      $display("FAIL fault_restart: got %h expected %h", dut_vec(), model_vec());
    end
    repeat (3) tick();
    n_checks++;
    if (bus.pll_resetb !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_reset_hold: got %b expected 0", bus.pll_resetb);
    end
    tick();
    n_checks++;
    if (bus.pll_resetb !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_new_attempt: got %b expected 1", bus.pll_resetb);
    end
  endtask

  task automatic test_chatter();
    bit done;
    int since_drop;
    bus.pll_locked = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      tick();
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL chatter_pre_model c=%0d: got %h expected %h", c, dut_vec(), model_vec());
      end
      if (m_phase == PH_STABLE && m_el == 5) done = 1'b1;
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL chatter_reach_stable: got timeout expected STABLE cycle 5");
    end
    bus.pll_locked = 1'b0;
    since_drop = 0;
    done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      tick();
      since_drop++;
      if (since_drop == 3) bus.pll_locked = 1'b1;
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL chatter_model c=%0d: got %h expected %h", c, dut_vec(), model_vec());
      end
      if (bus.pll_ready === 1'b1) done = 1'b1;
      else begin
        n_checks++;
        if (bus.sys_rst_n !== 1'b0 || bus.pll_resetb !== 1'b1) begin
          n_fail++;
          $display("FAIL chatter_hold: got sys_rst_n=%b resetb=%b expected 0/1",
                   bus.sys_rst_n, bus.pll_resetb);
        end
      end
    end
    // Dropout lands on the last STABLE cycle (lk=0 wins), relock is seen 3 cycles
    // later, and a full fresh STABLE window of 8 follows: RUN 14 cycles after the drop.
    n_checks++;
    if (since_drop != 14) begin
      n_fail++;
      $display("FAIL chatter_release: got %0d cycles expected 14", since_drop);
    end
  endtask

  task automatic test_run_loss();
    bit done;
    int dropped_at;
    bus.pll_locked = 1'b0;
    dropped_at = -1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (dropped_at < 0 && bus.sys_rst_n === 1'b0) dropped_at = c;
    end
    n_checks++;
    if (dropped_at < 0 || bus.pll_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL loss_release_drop: got sys_rst_n=%b after 3 cycles expected 0", bus.sys_rst_n);
    end
    n_checks++;
    if (bus.unlock_count !== 8'd1) begin
      n_fail++;
      $display("FAIL loss_unlock_count: got %0d expected 1", bus.unlock_count);
    end
    bus.pll_locked = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      tick();
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL loss_reseq_model c=%0d: got %h expected %h", c, dut_vec(), model_vec());
      end
      if (bus.pll_ready === 1'b1) done = 1'b1;
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL loss_reseq_run: got timeout expected RUN");
    end
    for (int i = 0; i < 300; i++) begin
      bus.pll_locked = 1'b0;
      repeat (3) tick();
      bus.pll_locked = 1'b1;
      done = 1'b0;
      for (int c = 0; c < 60 && !done; c++) begin
        tick();
        n_checks++;
        if (dut_vec() !== model_vec()) begin
          n_fail++;
          $display("FAIL loss_loop_model i=%0d: got %h expected %h", i, dut_vec(), model_vec());
        end
        if (bus.pll_ready === 1'b1) done = 1'b1;
      end
    end
    n_checks++;
    if (bus.unlock_count !== 8'd255) begin
      n_fail++;
      $display("FAIL loss_saturate: got %0d expected 255", bus.unlock_count);
    end
  endtask

  task automatic test_random();
    int hold;
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        bus.pll_locked = ($urandom_range(3, 0) != 0);
        hold = int'($urandom_range(40, 1));
      end
      hold--;
      bus.restart = ($urandom_range(199, 0) == 0);
      tick();
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL random_model i=%0d: got %h expected %h", i, dut_vec(), model_vec());
      end
    end
    bus.restart = 1'b0;
  endtask

  task automatic test_async_reset();
    bit done;
    bus.pll_locked = 1'b1;
    pulse_restart();
    done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      tick();
      if (m_phase == PH_STABLE && m_el == 3) done = 1'b1;
    end
    n_checks++;
    if (!done || bus.pll_resetb !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reach_stable: got resetb=%b expected 1 in STABLE", bus.pll_resetb);
    end
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (dut_vec() !== 14'h0) begin
      n_fail++;
      $display("FAIL async_reset_values: got %h expected %h", dut_vec(), 14'h0);
    end
    model_reset();
    @(negedge clock_in);
    reset_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL async_after_model c=%0d: got %h expected %h", c, dut_vec(), model_vec());
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_bringup();
    test_timeout();
    test_fault();
    test_chatter();
    test_run_loss();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
